// File: rtl/lenet_pkg.sv
// lenet_pkg -- shared definitions for the LeNet datapath blocks.
//   DATA_WIDTH_DEF : default FP16 word width
//   FP16_SIGN_BIT  : sign bit index of an FP16 word
//   strm_state_e   : streamer FSM state encoding (IDLE/STREAM/DONE)
package lenet_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FP16_SIGN_BIT  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } strm_state_e;

endpackage

// File: rtl/fp16_relu.sv
// fp16_relu -- combinational ReLU on one FP16 word.
// Any word with the sign bit set (including -0) becomes +0; others pass.
//   din  : input word
//   dout : rectified word
module fp16_relu
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SIGN_BIT   = FP16_SIGN_BIT
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  assign dout = din[SIGN_BIT] ? '0 : din;

endmodule

// File: rtl/conv_out_streamer.sv
// conv_out_streamer -- captures a flat feature map on start and streams it
// out one word per valid/ready handshake, word 0 first.
// Optional feature: define CONV_OUT_RELU_EN to rectify words on the output.
//   clk, reset : clock (rising edge), async active-high reset
//   start      : one-cycle pulse; fmap sampled when seen in IDLE
//   fmap       : flat map, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_data   : current word (0 when out_valid is low)
//   out_valid  : out_data valid
//   out_ready  : downstream accepts
//   out_last   : with word NUM_WORDS-1
//   busy       : state != IDLE
//   done       : one-cycle pulse after the final handshake
module conv_out_streamer
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WORDS  = 120
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] fmap,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  strm_state_e state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic cap_en;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] fmap_q;
  logic [DATA_WIDTH-1:0] word_raw, word_out;
  logic at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      fmap_q <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (cap_en) fmap_q <= fmap;
    end
  end

  assign at_last = (idx == LAST_IDX);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cap_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          idx_d   = '0;
          cap_en  = 1'b1;
        end
      end
      STREAM: begin
        // Index saturates at the last word; the final handshake leaves STREAM
        // so out_valid drops on the following cycle.
        if (out_ready) begin
          if (at_last) state_d = DONE;
          else         idx_d   = idx + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign word_raw = fmap_q[idx];

`ifdef CONV_OUT_RELU_EN
  fp16_relu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGN_BIT   (DATA_WIDTH - 1)
  ) u_relu (
    .din  (word_raw),
    .dout (word_out)
  );
`else
  assign word_out = word_raw;
`endif

  // Outputs decode straight from state so an async reset clears them at once.
  assign out_valid = (state == STREAM);
  assign out_data  = out_valid ? word_out : '0;
  assign out_last  = out_valid && at_last;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_conv_out_streamer.sv
// tb_conv_out_streamer -- scoreboard bench for conv_out_streamer.
// Three instances: 4-word (main scenarios), 120-word, 1-word.
// Honours CONV_OUT_RELU_EN in its expected-value model.
module tb_conv_out_streamer;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-word instance
  logic        start_a, rdy_a;
  logic [63:0] fmap_a;
  logic [15:0] data_a;
  logic        valid_a, last_a, busy_a, done_a;

  // 120-word instance
  logic          start_b, rdy_b;
  logic [1919:0] fmap_b;
  logic [15:0]   data_b;
  logic          valid_b, last_b, busy_b, done_b;

  // 1-word instance
  logic        start_c, rdy_c;
  logic [15:0] fmap_c;
  logic [15:0] data_c;
  logic        valid_c, last_c, busy_c, done_c;

  conv_out_streamer #(.DATA_WIDTH(16), .NUM_WORDS(4)) u_dut_a (
    .clk(clk), .reset(rst), .start(start_a), .fmap(fmap_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(rdy_a),
    .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  conv_out_streamer #(.DATA_WIDTH(16), .NUM_WORDS(120)) u_dut_b (
    .clk(clk), .reset(rst), .start(start_b), .fmap(fmap_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(rdy_b),
    .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  conv_out_streamer #(.DATA_WIDTH(16), .NUM_WORDS(1)) u_dut_c (
    .clk(clk), .reset(rst), .start(start_c), .fmap(fmap_c),
    .out_data(data_c), .out_valid(valid_c), .out_ready(rdy_c),
    .out_last(last_c), .busy(busy_c), .done(done_c)
  );

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_w(input logic [15:0] w);
`ifdef CONV_OUT_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic push_a(input logic [63:0] f);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.data = exp_w(f[k*16 +: 16]);
      e.last = (k == 3);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-word instance: scoreboard pops on handshakes,
  // stability check across stalls, zero data while invalid.
  logic        stall_p = 1'b0;
  logic [15:0] hold_d;
  logic        hold_l;
  always @(negedge clk) begin
    if (stall_p) begin
      chk("stall_valid", valid_a, 1);
      chk("stall_data", data_a, hold_d);
      chk("stall_last", last_a, hold_l);
    end
    if (valid_a && rdy_a) begin
      if (sb.size() == 0) chk("sb_underrun", sb.size(), 1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("word_data", data_a, e.data);
        chk("word_last", last_a, e.last);
      end
    end
    if (!valid_a) begin
      chk("idle_data", data_a, 0);
      chk("idle_last", last_a, 0);
    end
    stall_p = valid_a && !rdy_a;
    hold_d  = data_a;
    hold_l  = last_a;
  end

  task automatic wait_done_a(input string tag, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_a) begin
        seen = 1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [4] = '{1, 0, 0, 1};
    int cnt;
    logic [63:0] f_main;
    f_main = {16'h4400, 16'h3C00, 16'hC000, 16'h0000};

    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    rdy_a = 1; rdy_b = 1; rdy_c = 1;
    fmap_a = '0; fmap_b = '0; fmap_c = '0;
    tick();
    // start held during reset must not be taken
    start_a = 1'b1;
    fmap_a  = f_main;
    tick();
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_valid_c", valid_c, 0);
    start_a = 1'b0;
    rst = 1'b0;
    tick();
    chk("no_start_in_rst", busy_a, 0);

    // basic stream, ready held high
    fmap_a = f_main;
    start_a = 1'b1;
    push_a(f_main);
    tick();
    start_a = 1'b0;
    chk("c1_valid", valid_a, 1);
    chk("c1_busy", busy_a, 1);
    chk("c1_last", last_a, 0);
    tick(); tick(); tick();
    chk("c4_valid", valid_a, 1);
    chk("c4_last", last_a, 1);
    tick();
    chk("c5_done", done_a, 1);
    chk("c5_busy", busy_a, 1);
    chk("c5_valid", valid_a, 0);
    tick();
    chk("c6_done", done_a, 0);
    chk("c6_busy", busy_a, 0);
    chk("basic_sb_empty", sb.size(), 0);

    // backpressure 1,0,0,1,...
    start_a = 1'b1;
    push_a(f_main);
    tick();
    start_a = 1'b0;
    begin
      bit seen = 0;
      for (int c = 0; c < 40; c++) begin
        rdy_a = pat[c % 4][0];
        tick();
        if (done_a) begin
          seen = 1;
          break;
        end
      end
      chk("stall_done_seen", seen, 1);
    end
    rdy_a = 1'b1;
    chk("stall_sb_empty", sb.size(), 0);
    tick();

    // start re-pulsed mid-stream with a new fmap
    fmap_a = f_main;
    start_a = 1'b1;
    push_a(f_main);
    tick();
    start_a = 1'b0;
    tick();
    fmap_a  = {4{16'h7BFF}};
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cnt = 0;
    while (!done_a && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("repulse_len", cnt, 2);
    chk("repulse_sb_empty", sb.size(), 0);
    tick();
    chk("repulse_idle", busy_a, 0);

    // reset after handshake of word 1
    fmap_a = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    start_a = 1'b1;
    push_a(fmap_a);
    tick();
    start_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_data", data_a, 0);
    tick();
    rst = 1'b0;
    tick();
    fmap_a = {16'h0123, 16'hABCD, 16'h5555, 16'h8000};
    start_a = 1'b1;
    push_a(fmap_a);
    tick();
    start_a = 1'b0;
    chk("post_rst_w0", data_a, exp_w(16'h8000));
    wait_done_a("post_rst_done", 20);
    chk("post_rst_sb_empty", sb.size(), 0);
    tick();

    // 120-word instance, word k = k
    for (int k = 0; k < 120; k++) fmap_b[k*16 +: 16] = 16'(k);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    fmap_b = '0;
    for (int k = 0; k < 120; k++) begin
      chk("b_valid", valid_b, 1);
      chk("b_data", data_b, exp_w(16'(k)));
      chk("b_last", last_b, (k == 119) ? 1 : 0);
      tick();
    end
    chk("b_end_valid", valid_b, 0);
    chk("b_done", done_b, 1);
    tick();

    // 1-word instance
    fmap_c = 16'h8001;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_valid", valid_c, 1);
    chk("c_last", last_c, 1);
    chk("c_data", data_c, exp_w(16'h8001));
    tick();
    chk("c_end_valid", valid_c, 0);
    chk("c_done", done_c, 1);
    tick();
    chk("c_idle", busy_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_out_streamer.md
CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FP16 word width.
REQ-002 SHALL have parameter NUM_WORDS, default 120, number of words in the feature map (C5 output: 120 channels x 1 x 1).
REQ-003 SHALL have port clk, input, 1, single clock, rising edge; reset is asynchronous and active-high.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse: fmap is valid, begin streaming.
REQ-006 SHALL have port fmap, input, NUM_WORDS*DATA_WIDTH, flat feature map; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port out_data, output, DATA_WIDTH, current FP16 word.
REQ-008 SHALL have port out_valid, output, 1, out_data is valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-010 SHALL have port out_last, output, 1, high with the final word (index NUM_WORDS-1).
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the final handshake.

Function
REQ-013 SHALL have states IDLE, STREAM and DONE; IDLE->STREAM on start, STREAM->DONE on the handshake of word NUM_WORDS-1, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL capture fmap into an internal register on the clock edge where start is sampled in IDLE; later fmap changes SHALL NOT affect the stream.
REQ-015 SHALL assert out_valid with word 0 on the cycle after start is sampled (latency 1).
REQ-016 SHALL define a handshake as out_valid && out_ready at a rising edge; the word index, width ceil(log2(NUM_WORDS)) minimum 1, SHALL increment by 1 per handshake.
REQ-017 SHALL, with out_ready held high, stream one word per cycle: NUM_WORDS words in NUM_WORDS consecutive cycles.
REQ-018 SHALL hold out_data, out_last and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL NOT wrap the index past NUM_WORDS-1; the final handshake SHALL deassert out_valid on the next cycle.
REQ-020 SHALL ignore start in STREAM and DONE, with no recapture and no restart.
REQ-021 SHALL drive out_data to 0 and out_last to 0 whenever out_valid is low.
REQ-022 SHALL behave correctly with NUM_WORDS=1: out_last high on word 0.

Reset
REQ-023 SHALL, on reset asserted at any time including mid-stream, asynchronously force the state to IDLE, the index to 0, the capture register to 0, and out_valid, out_last, busy, done and out_data to 0.
REQ-024 SHALL not sample start on a cycle where reset is high; the first start after release SHALL be accepted.

Configuration
REQ-025 SHALL provide macro CONV_OUT_RELU_EN; when it is defined, any word with sign bit DATA_WIDTH-1 set, including -0, SHALL be output as 0, and other words SHALL pass unchanged.
REQ-026 SHALL, when CONV_OUT_RELU_EN is undefined, output words bit-exact to the captured fmap; timing SHALL be identical in both builds, with ReLU purely combinational on the output.

Structure
REQ-027 SHALL take DATA_WIDTH default, the state enum type and the FP16 sign-bit index constant from the shared package lenet_pkg.
REQ-028 SHALL place the ReLU in a single combinational sub-module fp16_relu, instantiated only under CONV_OUT_RELU_EN.

Verification
REQ-029 SHALL cover reset, NUM_WORDS=4, fmap={16'h4400,16'h3C00,16'hC000,16'h0000} (word3..word0), start, out_ready=1 -> out_valid high on cycles 1-4 with 0000, C000, 3C00, 4400; out_last on cycle 4; done on cycle 5; busy cycles 1-5.
REQ-030 SHALL cover the same fmap with CONV_OUT_RELU_EN defined -> word1 output as 0000; all other words unchanged.
REQ-031 SHALL cover out_ready toggling 1,0,0,1,... -> every word held stable during stalls; all 4 words delivered exactly once, in order.
REQ-032 SHALL cover start re-pulsed during STREAM with fmap changed to all 16'h7BFF -> the stream still carries the original captured values, with no restart.
REQ-033 SHALL cover reset asserted after the handshake of word 1 -> out_valid and busy go 0 immediately; the next start streams from word 0.
REQ-034 SHALL cover NUM_WORDS=120 with fmap word k = k, out_ready=1 -> words 0..119 on 120 consecutive cycles; out_last only with 119.
